// File: rtl/max7219_col_scan_if.sv
// Column stream between the scanner and the MAX7219 SPI serialiser.
// Standard valid/ready handshake: a column transfers on any clock edge
// where col_valid and col_ready are both high.
interface max7219_col_scan_if #(
  parameter int N_MAT = 2,
  parameter int IDX_W = $clog2(8 * N_MAT)
);
  logic             col_valid;
  logic             col_ready;
  logic [7:0]       col_data;
  logic [IDX_W-1:0] col_idx;

  modport master (output col_valid, col_data, col_idx, input  col_ready);
  modport slave  (input  col_valid, col_data, col_idx, output col_ready);
endinterface

// File: rtl/max7219_col_scan.sv
// Column scanner for N_MAT cascaded 8x8 MAX7219 matrices.
// A start request latches the pixel frame and the column order into shadow
// registers, then streams one column byte per handshake in chain order:
// highest-numbered matrix first. In loop mode the next frame is latched at
// the last transfer and scanning continues with no bubble.
module max7219_col_scan #(
  parameter int N_MAT = 2,
  parameter int IDX_W = $clog2(8 * N_MAT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 dir_i,
  input  logic                 loop_i,
  input  logic [64*N_MAT-1:0]  pixels_i,
  output logic                 busy_o,
  output logic                 frame_done_o,
  max7219_col_scan_if.master   col
);

  localparam int               PIX_W  = 64 * N_MAT;
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(8 * N_MAT - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic               valid_q, valid_d;
  logic [7:0]         data_q, data_d;
  logic               done_q, done_d;
  logic [PIX_W-1:0]   pix_sh_q, pix_sh_d;
  logic               dir_sh_q, dir_sh_d;

  // Gather column b of matrix m into a byte: row 0 lands in the MSB.
  function automatic logic [7:0] col_byte(input logic [PIX_W-1:0] pix,
                                          input logic             dsel,
                                          input logic [IDX_W-1:0] k);
    logic [7:0] v;
    int         m;
    int         b;
    m = N_MAT - 1 - int'(k) / 8;
    b = dsel ? 7 - int'(k) % 8 : int'(k) % 8;
    v = '0;
    for (int r = 0; r < 8; r++) begin
      v[7-r] = pix[64*m + 8*r + b];
    end
    return v;
  endfunction

  wire xfer = valid_q && col.col_ready;

  // Next-state logic: frame load, column advance and end-of-frame handling.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // this block leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    k_d      = k_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    pix_sh_d = pix_sh_q;
    dir_sh_d = dir_sh_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pix_sh_d = pixels_i;
          dir_sh_d = dir_i;
          k_d      = '0;
          valid_d  = 1'b1;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (xfer) begin
          if (k_q == LAST_K) begin
            done_d = 1'b1;
            if (loop_i) begin
              // Latch the next frame and present its column 0 straight away.
              pix_sh_d = pixels_i;
              dir_sh_d = dir_i;
              k_d      = '0;
            end else begin
              valid_d = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            k_d = k_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The column byte always tracks the next shadow/index, so it holds
    // whenever they hold (stalls, idle) and changes together with col_idx.
    data_d = col_byte(pix_sh_d, dir_sh_d, k_d);
  end

  // State, index, output and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
      // NOTE: the shadow frame is ordinary flops, not a RAM, so it is cleared
      // with everything else; col_data then reads 8'h00 straight out of reset.
      pix_sh_q <= '0;
      dir_sh_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before the edge, independent of statement order.
      state_q  <= state_d;
      k_q      <= k_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      done_q   <= done_d;
      pix_sh_q <= pix_sh_d;
      dir_sh_q <= dir_sh_d;
    end
  end

  assign col.col_valid = valid_q;
  assign col.col_data  = data_q;
  assign col.col_idx   = k_q;
  assign busy_o        = (state_q == S_SCAN);
  assign frame_done_o  = done_q;

endmodule

// File: doc/max7219_col_scan.md
# max7219_col_scan

Parameterised column scanner for a chain of N_MAT cascaded 8x8 MAX7219 LED matrices. On `start` it snapshots a frame of pixels. It then emits one 8-bit column byte per valid/ready transfer, in the order the downstream SPI serialiser shifts them into the chain. It sits between the frame buffer and the MAX7219 command/SPI block. It replaces the fixed two-matrix, free-running column selector with a handshaked, frame-latched, optionally looping engine.

## Interface

Parameters:
- N_MAT, default 2: number of cascaded 8x8 matrices; must be at least 1.
- IDX_W, default $clog2(8*N_MAT): width of the column index; derived, do not override.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle request to begin a frame; only accepted in IDLE.
- dir, in, 1: within-matrix column order; latched at frame load.
- loop, in, 1: continuous mode; sampled when the last column transfers.
- pixels, in, 64*N_MAT: frame. Matrix m occupies bits [64m+63:64m]. Row r of matrix m is byte [64m+8r+7:64m+8r]. Bit b of that byte is column b.
- col_valid, out, 1: col_data/col_idx hold a column.
- col_ready, in, 1: downstream accepts the column.
- col_data, out, 8: column byte; MSB is row 0, LSB is row 7.
- col_idx, out, IDX_W: scan index k of the presented column, 0..8*N_MAT-1.
- busy, out, 1: high in SCAN.
- frame_done, out, 1: one-cycle pulse after the last column of a frame transfers.

## Operation

- Shadow registers: pix_sh (64*N_MAT bits) and dir_sh. They are loaded at frame load only, so changes on `pixels` or `dir` mid-frame have no effect.
- Scan index k maps to a matrix and a column:
  - m = N_MAT-1 - k/8, so the highest-numbered matrix goes first.
  - b = 7 - k%8 when dir_sh=1; b = k%8 when dir_sh=0.
- Column byte: col_data[7-r] = pix_sh[64m + 8r + b] for r = 0..7.
- States:
  - IDLE: col_valid=0, busy=0. On start=1, load the shadows, set k=0, register col_data/col_idx for k=0, assert col_valid, go to SCAN.
  - SCAN: busy=1. A transfer occurs when col_valid and col_ready are both high. On a transfer with k < 8*N_MAT-1: k <= k+1 and register the next column. On a transfer with k = 8*N_MAT-1 (last column):
    - If loop=1: reload the shadows from the current `pixels`/`dir`, set k=0, present column 0 of the new frame with col_valid held high (no bubble), pulse frame_done, stay in SCAN.
    - If loop=0: col_valid <= 0, pulse frame_done, go to IDLE.
- start in SCAN is ignored. A start in the same cycle as a final, non-loop transfer is also ignored; the next frame needs a fresh start in IDLE.
- With col_ready=0, col_data, col_idx and col_valid hold stable, with no bound on the stall length.
- k wraps only through the last-column rule; it never increments past 8*N_MAT-1.
- col_idx equals k of the presented column.

## Timing

- Reset (asynchronous): state=IDLE, k=0, col_valid=0, col_data=8'h00, col_idx=0, busy=0, frame_done=0, shadows=0.
- Reset mid-frame aborts immediately; no frame_done pulse is produced.
- Latency: start sampled at edge t gives col_valid=1 with column 0 after edge t, so col_data/col_idx are registered and valid the cycle after start.
- Throughput: one column per cycle with col_ready tied high. A full frame takes 8*N_MAT transfer cycles. Non-loop mode adds at least one idle cycle before the next start can be accepted.
- frame_done is high for exactly the cycle after the last transfer edge, coincident with col_valid=0 (non-loop) or with column 0 of the new frame (loop).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Ordering, N_MAT=2, dir=1, only pixels[71] set, col_ready=1, start pulse: k=0 gives col_data=8'h80 and col_idx=0; k=1..15 give 8'h00; frame_done pulses once after k=15; busy is high for 16 cycles.
- Reverse order, same frame with dir=0: 8'h80 appears at k=7. Then only pixels[120] set: 8'h01 at k=0. Only pixels[0] set: 8'h80 at k=8.
- Backpressure: drop col_ready for 5 cycles at k=3. col_data/col_idx stay frozen at k=3 with col_valid=1, and no column is skipped or duplicated.
- Snapshot and ignored start, dir=1, only pixels[71] set at start: change pixels to all-ones mid-frame and pulse start at k=6. Output still matches the original frame (8'h80 at k=0 only, 8'h00 elsewhere), and only one frame_done pulse occurs.
- Loop mode, loop=1, pixels changed before the last transfer: column 0 of the new frame follows k=15 with col_valid never dropping; frame_done pulses; busy stays 1.
- Reset mid-frame: assert rst_n=0 at k=9. All outputs go to reset values asynchronously, no frame_done pulse occurs, and a following start restarts at k=0.
